// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
// Issues sequential word fetches to instruction memory. Up to FIFO_DEPTH
// requests and buffered instructions may be outstanding. Memory returns
// responses in order, and they are queued for decode.
// A control-flow redirect does three things: it flushes the buffer, it
// marks every outstanding response to be discarded, and it restarts
// fetching at the word-aligned target.
// Optional feature macro: FETCH_PERF_CNT_EN. When it is defined, the
// perf_stall_cycles port is added. It counts cycles in which decode is
// ready but no instruction is available.
module inst_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     perf_stall_cycles,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(32'd4);
  localparam logic [XLEN-1:0]  ALIGN_MASK = ~(XLEN'(32'd3));
  localparam logic [OCC_W-1:0] DEPTH_OCC  = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1'b1);

  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  resp_pc_r;    // address of the next response that will be kept
  logic [CNT_W-1:0] in_flight_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic [CNT_W-1:0] fifo_count_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [XLEN-1:0]  fifo_inst_r [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_pc_r   [FIFO_DEPTH];

  logic [OCC_W-1:0] occupancy_s;
  logic             resp_s;
  logic             drop_s;
  logic             push_s;
  logic             req_valid_s;
  logic             req_fire_s;
  logic             out_valid_s;
  logic             pop_s;
  logic [CNT_W-1:0] in_flight_nxt_s;

  // Handshake and bookkeeping decisions for the current cycle
  always_comb begin
    occupancy_s     = OCC_W'(in_flight_r) + OCC_W'(fifo_count_r);
    // A response with nothing outstanding belongs to a pre-reset request
    resp_s          = imem_resp_valid && (in_flight_r != CNT_ZERO);
    drop_s          = resp_s && (redirect_valid || (drop_cnt_r != CNT_ZERO));
    push_s          = resp_s && !drop_s;
    req_valid_s     = !RST && !redirect_valid && (occupancy_s < DEPTH_OCC);
    req_fire_s      = req_valid_s && imem_req_ready;
    out_valid_s     = !RST && !redirect_valid && (fifo_count_r != CNT_ZERO);
    pop_s           = out_valid_s && out_ready;
    in_flight_nxt_s = in_flight_r + CNT_W'(req_fire_s) - CNT_W'(resp_s);
  end

  // Output drive, forced to reset values while RST is high
  always_comb begin
    imem_req_valid = req_valid_s;
    out_valid      = out_valid_s;
    imem_req_addr  = RESET_PC;
    out_inst       = {XLEN{1'b0}};
    out_pc         = {XLEN{1'b0}};
    if (RST) begin
      imem_req_addr = RESET_PC;
    end else begin
      imem_req_addr = pc_r;
      out_inst      = fifo_inst_r[rd_ptr_r];
      out_pc        = fifo_pc_r[rd_ptr_r];
    end
  end

  // Fetch PC, outstanding/discard counters and FIFO pointers
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_r         <= RESET_PC;
      resp_pc_r    <= RESET_PC;
      in_flight_r  <= CNT_ZERO;
      drop_cnt_r   <= CNT_ZERO;
      fifo_count_r <= CNT_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      wr_ptr_r     <= PTR_ZERO;
    end else if (redirect_valid) begin
      pc_r         <= redirect_pc & ALIGN_MASK;
      resp_pc_r    <= redirect_pc & ALIGN_MASK;
      in_flight_r  <= in_flight_nxt_s;
      drop_cnt_r   <= in_flight_nxt_s;
      fifo_count_r <= CNT_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      wr_ptr_r     <= PTR_ZERO;
    end else begin
      if (req_fire_s) begin
        pc_r <= pc_r + PC_STEP;
      end
      in_flight_r <= in_flight_nxt_s;
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r - CNT_W'(1'b1);
      end
      if (push_s) begin
        wr_ptr_r  <= wr_ptr_r + PTR_ONE;
        resp_pc_r <= resp_pc_r + PC_STEP;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      fifo_count_r <= fifo_count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Instruction buffer storage: the word and the address it was fetched from
  always_ff @(posedge CLK) begin
    if (push_s && !RST && !redirect_valid) begin
      fifo_inst_r[wr_ptr_r] <= imem_resp_data;
      fifo_pc_r[wr_ptr_r]   <= resp_pc_r;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating count of cycles where decode waits on fetch
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_stall_cycles <= 32'd0;
    end else if (out_ready && !out_valid_s && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit.
// A transaction-level model tracks the fetch PC, the outstanding requests
// with discard marks, and the instruction buffer as a queue. An in-order
// memory model has a random latency. The DUT outputs are compared against
// the model in every cycle. Directed scenarios add literal expectations.
module tb_inst_fetch_unit;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        CLK, RST;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
`endif

  inst_fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_pend_addr [$];
  bit          m_pend_drop [$];
  logic [31:0] m_fifo_inst [$];
  logic [31:0] m_fifo_pc   [$];
  // memory model
  logic [31:0] mem_data_q [$];
  int          mem_due_q  [$];
  int          lat_min = 1, lat_max = 1, resp_pct = 100;
  int          cyc = 0;
  // observed DUT events
  logic [31:0] acc_log [$];
  int          acc_cyc [$];
  logic [31:0] dlv_log [$];
  int          first_ov_cyc = -1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void clear_logs();
    acc_log.delete(); acc_cyc.delete(); dlv_log.delete(); first_ov_cyc = -1;
  endfunction

  task automatic step(input logic rst, input logic rdy, input logic redir,
                      input logic [31:0] rpc, input logic ordy);
    logic        resp, drop, exp_rv, exp_ov;
    logic [31:0] rdata, a, exp_addr, exp_inst, exp_opc;
    @(negedge CLK);
    resp  = !rst && (mem_data_q.size() > 0) && (mem_due_q[0] <= cyc) &&
            (int'($urandom_range(99)) < resp_pct);
    rdata = resp ? mem_data_q[0] : $urandom;
    RST = rst; imem_req_ready = rdy; imem_resp_valid = resp; imem_resp_data = rdata;
    redirect_valid = redir; redirect_pc = rpc; out_ready = ordy;
    #1;
    if (rst) begin
      exp_rv = 1'b0; exp_ov = 1'b0; exp_addr = RPC; exp_inst = 32'd0; exp_opc = 32'd0;
    end else begin
      exp_rv   = !redir && ((m_pend_addr.size() + m_fifo_pc.size()) < DEPTH);
      exp_ov   = !redir && (m_fifo_pc.size() > 0);
      exp_addr = m_pc;
      exp_inst = exp_ov ? m_fifo_inst[0] : 32'd0;
      exp_opc  = exp_ov ? m_fifo_pc[0] : 32'd0;
    end
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("req_addr", imem_req_addr, exp_addr);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (rst || exp_ov) begin
      chk("out_inst", out_inst, exp_inst);
      chk("out_pc", out_pc, exp_opc);
    end
    if (imem_req_valid && rdy) begin acc_log.push_back(imem_req_addr); acc_cyc.push_back(cyc); end
    if (out_valid && ordy) dlv_log.push_back(out_pc);
    if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
    // advance the model to the next cycle
    if (rst) begin
      m_pc = RPC;
      m_pend_addr.delete(); m_pend_drop.delete();
      m_fifo_inst.delete(); m_fifo_pc.delete();
      mem_data_q.delete(); mem_due_q.delete();
    end else begin
      drop = 1'b1; a = 32'd0;
      if (resp) begin
        void'(mem_data_q.pop_front()); void'(mem_due_q.pop_front());
        a = m_pend_addr.pop_front(); drop = m_pend_drop.pop_front();
      end
      if (redir) begin
        m_fifo_inst.delete(); m_fifo_pc.delete();
        foreach (m_pend_drop[i]) m_pend_drop[i] = 1'b1;
        m_pc = rpc & 32'hFFFF_FFFC;
      end else begin
        if (exp_ov && ordy) begin void'(m_fifo_inst.pop_front()); void'(m_fifo_pc.pop_front()); end
        if (resp && !drop) begin m_fifo_inst.push_back(rdata); m_fifo_pc.push_back(a); end
        if (exp_rv && rdy) begin
          m_pend_addr.push_back(m_pc); m_pend_drop.push_back(1'b0);
          mem_data_q.push_back($urandom);
          mem_due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
  endtask

  int rel;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_before;
`endif

  initial begin
    RST = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;

    // reset release, 1-cycle memory, decode always ready
    do_reset();
    clear_logs(); rel = cyc;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("first_acc_cycle", 32'(acc_cyc.size() > 0 ? acc_cyc[0] : -1), 32'(rel));
    chk("acc0", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'h0);
    chk("acc1", acc_log.size() > 1 ? acc_log[1] : 32'hDEAD_BEEF, 32'h4);
    chk("acc2", acc_log.size() > 2 ? acc_log[2] : 32'hDEAD_BEEF, 32'h8);
    chk("first_latency", 32'(first_ov_cyc), 32'(rel + 2));
    chk("dlv0", dlv_log.size() > 0 ? dlv_log[0] : 32'hDEAD_BEEF, 32'h0);
    chk("dlv1", dlv_log.size() > 1 ? dlv_log[1] : 32'hDEAD_BEEF, 32'h4);
    chk("dlv2", dlv_log.size() > 2 ? dlv_log[2] : 32'hDEAD_BEEF, 32'h8);

    // decode stalled for 10 cycles
    do_reset(); clear_logs();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("stall_acc_le2", 32'(acc_log.size() <= 2), 32'd1);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    clear_logs();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("stall_dlv0", dlv_log.size() > 0 ? dlv_log[0] : 32'hDEAD_BEEF, 32'h0);
    chk("stall_dlv1", dlv_log.size() > 1 ? dlv_log[1] : 32'hDEAD_BEEF, 32'h4);

    // redirect to 0x103 with two requests outstanding
    do_reset(); lat_min = 3; lat_max = 3;
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h103, 1'b0);
    clear_logs();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("redir_acc", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'h100);
    chk("redir_dlv", dlv_log.size() > 0 ? dlv_log[0] : 32'hDEAD_BEEF, 32'h100);

    // redirect in the same cycle as a response
    do_reset(); lat_min = 1; lat_max = 1;
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
    chk("redir_resp_ov", 32'(out_valid), 32'd0);
    clear_logs();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("redir_resp_dlv", dlv_log.size() > 0 ? dlv_log[0] : 32'hDEAD_BEEF, 32'h200);

    // fetch PC wrap at the top of the address space
    do_reset();
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    clear_logs();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk("wrap_acc0", acc_log.size() > 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_acc1", acc_log.size() > 1 ? acc_log[1] : 32'hDEAD_BEEF, 32'h0);
    chk("wrap_dlv1", dlv_log.size() > 1 ? dlv_log[1] : 32'hDEAD_BEEF, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    // memory stalled with decode ready
    do_reset(); resp_pct = 0;
    perf_before = perf_stall_cycles;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    @(posedge CLK); #1;
    chk("perf_stall_ge5", 32'(perf_stall_cycles >= perf_before + 32'd5), 32'd1);
    resp_pct = 100;
`endif

    // randomized traffic
    do_reset(); lat_min = 1; lat_max = 4; resp_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(499) == 0, $urandom_range(3) != 0, $urandom_range(19) == 0,
           $urandom, $urandom_range(3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
